ddr3_multichan_burst_writer: RTL and testbench
==============================================

Name: ddr3_multichan_burst_writer

Overview:
- Single-clock DDR3 write master that drains NUM_CH show-ahead pixel FIFOs in the ddr3_clk domain into per-channel frame buffers.
- Each channel owns a base address, a frame length and an optional double-buffer (ping-pong) region.
- A round-robin arbiter issues fixed-length Avalon-MM write bursts from any channel whose FIFO holds at least one full burst.
- Successor to the single-channel 2-bit pixel writer; the upstream CDC FIFOs and pixel packers stay outside this block.

Parameters:
- NUM_CH, 2, number of input channels (1..8).
- BURST_LEN, 8, beats per burst; power of two, 1..64.
- FRAME_WORDS, 21600, 256-bit words per frame per channel; must be a multiple of BURST_LEN.
- LEVEL_W, 8, width of each channel's FIFO level input.
- DOUBLE_BUF, 1, 1 = alternate between two buffers per channel each frame; 0 = single buffer.

Ports:
- ddr3_clk  in  1  clock
- ddr3_clk_reset  in  1  synchronous active-high reset
- ch_enable  in  NUM_CH  per-channel enable; sampled only in ST_ARB
- ch_base_addr  in  NUM_CH*27  per-channel buffer-0 base, in 256-bit word units; must be stable while the channel is enabled
- ch_fifo_data  in  NUM_CH*256  show-ahead FIFO head per channel
- ch_fifo_level  in  NUM_CH*LEVEL_W  FIFO used-words per channel
- ch_fifo_read  out  NUM_CH  pop strobe per channel
- ddr3_write_address  out  27  burst start address (word units)
- ddr3_write_data  out  256  write data
- ddr3_write  out  1  Avalon write
- ddr3_waitrequest  in  1  Avalon waitrequest
- ddr3_burstcount  out  8  constant BURST_LEN
- ch_frame_done  out  NUM_CH  one-cycle pulse when a channel's final burst of a frame is accepted
- ch_buf_sel  out  NUM_CH  buffer currently being written per channel
- busy  out  1  high in ST_BURST

Behaviour:
- Reset values: ddr3_write=0, ch_fifo_read=0, ch_frame_done=0, ch_buf_sel=0, busy=0, ddr3_write_address=0, all per-channel word counters=0, round-robin pointer=0, state=ST_ARB.
- ST_ARB: a channel is eligible when ch_enable[i]=1 and ch_fifo_level[i] >= BURST_LEN. Grant goes to the first eligible channel searching upward (modulo NUM_CH) from the pointer. On grant:
  - register grant index g;
  - ddr3_write_address <= base[g] + buf_sel[g]*FRAME_WORDS + word_cnt[g];
  - move to ST_BURST.
  - With no eligible channel, stay in ST_ARB. Grant-to-first-write latency is 1 cycle.
- ST_BURST:
  - ddr3_write=1; ddr3_write_data = ch_fifo_data[g] (combinational mux on registered g).
  - Address and burstcount are held constant for the whole burst.
  - A beat is accepted when ddr3_write && !ddr3_waitrequest; ch_fifo_read[g] is asserted in that same cycle only.
  - While waitrequest is high, the beat counter does not advance and there is no pop.
- Last beat accepted (beat counter == BURST_LEN-1):
  - word_cnt[g] += BURST_LEN;
  - pointer <= g+1 mod NUM_CH;
  - return to ST_ARB. ddr3_write is low for at least 1 cycle between bursts.
- Frame wrap: if word_cnt[g] + BURST_LEN == FRAME_WORDS, then word_cnt[g] <= 0, ch_frame_done[g] pulses for 1 cycle, and ch_buf_sel[g] toggles if DOUBLE_BUF=1 (stays 0 if DOUBLE_BUF=0).
- Counter width is clog2(FRAME_WORDS+1). Address addition wraps modulo 2^27.
- ch_enable deasserting mid-burst does not abort the burst. A disabled channel keeps its word_cnt and buf_sel and resumes at the same address when re-enabled.
- Every enabled channel with data is granted within NUM_CH bursts (starvation-free).
- Reset mid-burst: all state returns to reset values on the next edge and no further pops occur. The upstream FIFOs must be cleared by the same reset.
- ddr3_burstcount is tied to BURST_LEN.

Test Plan:
- NUM_CH=1, BURST_LEN=8, level=8, waitrequest=0 → address = base; 8 consecutive write cycles; 8 pops; write low for ≥1 cycle; next burst at base+8.
- NUM_CH=2, both levels ≥ 8 continuously → grants alternate 0,1,0,1; ch0 addresses base0, base0+8; ch1 addresses base1, base1+8.
- Waitrequest high on beats 0, 3 and 7 for 2 cycles each → still exactly 8 pops; data order matches FIFO order; address and burstcount stable throughout.
- FRAME_WORDS=16, DOUBLE_BUF=1 → bursts at base, base+8, base+16, base+24, then base again; ch_frame_done pulses after the 2nd and 4th bursts; ch_buf_sel toggles 0→1→0.
- ch_enable[1]=0 with ch1 level=20 → only ch0 is granted; after re-enable, ch1 resumes at its saved word_cnt address.
- Reset asserted on beat 4 → ddr3_write=0 and no pops on the next cycle; after release, the first burst starts at base with word_cnt=0.

Source files
------------

// File: rtl/ddr3_multichan_burst_writer.sv
// ddr3_multichan_burst_writer
// Round-robin DDR3 write master. Drains NUM_CH show-ahead pixel FIFOs into
// per-channel frame buffers using fixed-length Avalon-MM write bursts.
// Each channel can ping-pong between two frame buffers (DOUBLE_BUF=1).
//
// Ports:
//   ddr3_clk, ddr3_clk_reset        clock, synchronous active-high reset
//   ch_enable[NUM_CH]               per-channel enable (sampled while arbitrating)
//   ch_base_addr[NUM_CH*27]         buffer-0 base per channel, word units
//   ch_fifo_data/level/read         show-ahead FIFO head, fill level, pop strobe
//   ddr3_write_address/data/write   Avalon-MM write command
//   ddr3_waitrequest, ddr3_burstcount
//   ch_frame_done[NUM_CH]           pulse after a channel's last burst of a frame
//   ch_buf_sel[NUM_CH]              buffer currently written per channel
//   busy                            high while a burst is in progress
//
// state    | meaning
// ST_ARB   | pick next eligible channel, latch burst address
// ST_BURST | stream BURST_LEN beats from the granted FIFO
module ddr3_multichan_burst_writer #(
  parameter int NUM_CH      = 2,
  parameter int BURST_LEN   = 8,
  parameter int FRAME_WORDS = 21600,
  parameter int LEVEL_W     = 8,
  parameter int DOUBLE_BUF  = 1
) (
  input  logic                    ddr3_clk,
  input  logic                    ddr3_clk_reset,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*27-1:0]    ch_base_addr,
  input  logic [NUM_CH*256-1:0]   ch_fifo_data,
  input  logic [NUM_CH*LEVEL_W-1:0] ch_fifo_level,
  output logic [NUM_CH-1:0]       ch_fifo_read,
  output logic [26:0]             ddr3_write_address,
  output logic [255:0]            ddr3_write_data,
  output logic                    ddr3_write,
  input  logic                    ddr3_waitrequest,
  output logic [7:0]              ddr3_burstcount,
  output logic [NUM_CH-1:0]       ch_frame_done,
  output logic [NUM_CH-1:0]       ch_buf_sel,
  output logic                    busy
);

  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int CNT_W  = $clog2(FRAME_WORDS + 1);

  typedef enum logic {ST_ARB, ST_BURST} state_t;
  state_t state, state_nxt;

  logic [26:0]       base_arr [NUM_CH];
  logic [255:0]      data_arr [NUM_CH];
  logic [NUM_CH-1:0] eligible;
  logic [CNT_W-1:0]  word_cnt [NUM_CH];
  logic [NUM_CH-1:0] buf_sel;
  logic [CH_W-1:0]   ptr;
  logic [CH_W-1:0]   g;
  logic [CH_W-1:0]   pick;
  logic              found;
  logic [BEAT_W-1:0] beat_cnt;
  logic [26:0]       grant_addr;
  logic              accept;
  logic              last_beat;
  logic              wrap;
  int                idx;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      base_arr[i] = ch_base_addr[i*27 +: 27];
      data_arr[i] = ch_fifo_data[i*256 +: 256];
      eligible[i] = ch_enable[i] &&
                    (32'(ch_fifo_level[i*LEVEL_W +: LEVEL_W]) >= 32'(BURST_LEN));
    end
  end

  // First eligible channel searching upward from the round-robin pointer.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!found && eligible[idx]) begin
        found = 1'b1;
        pick  = CH_W'(idx);
      end
    end
  end

  // Address arithmetic wraps modulo 2^27 by truncation.
  assign grant_addr = base_arr[pick]
                    + (buf_sel[pick] ? 27'(FRAME_WORDS) : 27'd0)
                    + 27'(word_cnt[pick]);

  // Reset gates the handshake so nothing is popped or written in the reset cycle.
  assign accept    = (state == ST_BURST) && !ddr3_waitrequest && !ddr3_clk_reset;
  assign last_beat = (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign wrap      = ((32'(word_cnt[g]) + 32'(BURST_LEN)) == 32'(FRAME_WORDS));

  always_ff @(posedge ddr3_clk) begin
    if (ddr3_clk_reset) state <= ST_ARB;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:   if (found) state_nxt = ST_BURST;
      ST_BURST: if (accept && last_beat) state_nxt = ST_ARB;
      default:  state_nxt = ST_ARB;
    endcase
  end

  always_comb begin
    ddr3_write   = (state == ST_BURST) && !ddr3_clk_reset;
    busy         = (state == ST_BURST);
    ch_fifo_read = '0;
    if (accept) ch_fifo_read[g] = 1'b1;
  end

  always_ff @(posedge ddr3_clk) begin
    if (ddr3_clk_reset) begin
      g                  <= '0;
      ptr                <= '0;
      beat_cnt           <= '0;
      ddr3_write_address <= '0;
      buf_sel            <= '0;
      ch_frame_done      <= '0;
      for (int i = 0; i < NUM_CH; i++) word_cnt[i] <= '0;
    end else begin
      ch_frame_done <= '0;
      if (state == ST_ARB && found) begin
        g                  <= pick;
        ddr3_write_address <= grant_addr;
        beat_cnt           <= '0;
      end
      if (accept) begin
        if (last_beat) begin
          beat_cnt <= '0;
          ptr      <= (g == CH_W'(NUM_CH - 1)) ? '0 : g + 1'b1;
          if (wrap) begin
            word_cnt[g]      <= '0;
            ch_frame_done[g] <= 1'b1;
            if (DOUBLE_BUF != 0) buf_sel[g] <= ~buf_sel[g];
          end else begin
            word_cnt[g] <= word_cnt[g] + CNT_W'(BURST_LEN);
          end
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  assign ddr3_write_data = data_arr[g];
  assign ddr3_burstcount = 8'(BURST_LEN);
  assign ch_buf_sel      = buf_sel;

endmodule

// File: tb/tb_ddr3_multichan_burst_writer.sv
// Randomized bench for ddr3_multichan_burst_writer: FIFO environment built
// from queues plus a transaction-level reference of arbitration, addressing
// and frame wrapping.
module tb_ddr3_multichan_burst_writer;

  localparam int NCH = 2;
  localparam int BL  = 8;
  localparam int FW  = 16;
  localparam int LW  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NCH-1:0]       en;
  logic [NCH*27-1:0]    base;
  logic [NCH*256-1:0]   fdata;
  logic [NCH*LW-1:0]    flevel;
  logic [NCH-1:0]       fread;
  logic [26:0]          waddr;
  logic [255:0]         wdata;
  logic                 wr;
  logic                 wreq;
  logic [7:0]           bc;
  logic [NCH-1:0]       done;
  logic [NCH-1:0]       bsel;
  logic                 busy;

  ddr3_multichan_burst_writer #(
    .NUM_CH(NCH), .BURST_LEN(BL), .FRAME_WORDS(FW), .LEVEL_W(LW), .DOUBLE_BUF(1)
  ) dut (
    .ddr3_clk(clk),
    .ddr3_clk_reset(rst),
    .ch_enable(en),
    .ch_base_addr(base),
    .ch_fifo_data(fdata),
    .ch_fifo_level(flevel),
    .ch_fifo_read(fread),
    .ddr3_write_address(waddr),
    .ddr3_write_data(wdata),
    .ddr3_write(wr),
    .ddr3_waitrequest(wreq),
    .ddr3_burstcount(bc),
    .ch_frame_done(done),
    .ch_buf_sel(bsel),
    .busy(busy)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  logic [255:0] fq [NCH][$];
  logic [26:0]  base_v [NCH];

  bit           m_busy;
  int           m_g, m_beat, m_ptr;
  int           m_wc [NCH];
  bit [NCH-1:0] m_buf, m_done;
  logic [26:0]  m_addr;
  int           bursts, frames;
  bit           did_reset, post_rst;

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_beat = 0; m_ptr = 0;
    m_buf = '0; m_done = '0; m_addr = '0;
    for (int c = 0; c < NCH; c++) m_wc[c] = 0;
  endtask

  task automatic drive_fifos();
    for (int c = 0; c < NCH; c++) begin
      fdata[c*256 +: 256] = (fq[c].size() > 0) ? fq[c][0] : '0;
      flevel[c*LW +: LW]  = (fq[c].size() > 255) ? 8'd255 : 8'(fq[c].size());
    end
  endtask

  initial begin
    logic [NCH-1:0] exp_rd;
    logic [255:0]   word;
    bit             found;
    int             idx;

    base_v[0] = 27'h0001000;
    base_v[1] = 27'h7FFFFF8;
    for (int c = 0; c < NCH; c++) base[c*27 +: 27] = base_v[c];
    rst = 1'b1; en = '0; wreq = 1'b0;
    bursts = 0; frames = 0; did_reset = 0; post_rst = 0;
    model_reset();
    drive_fifos();

    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_write", 256'(wr), 256'(0));
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_addr", 256'(waddr), 256'(0));
    check("rst_read", 256'(fread), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_bufsel", 256'(bsel), 256'(0));
    @(posedge clk); #1;
    en = '1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < NCH; c++) begin
        if (fq[c].size() < 40 && $urandom_range(0, 2) != 0) begin
          for (int w = 0; w < 8; w++) word[w*32 +: 32] = $urandom;
          fq[c].push_back(word);
        end
        if ($urandom_range(0, 49) == 0) en[c] = ~en[c];
      end
      wreq = ($urandom_range(0, 3) == 0);
      rst  = (!did_reset && cyc > 1500 && m_busy && m_beat == 4);
      drive_fifos();

      @(negedge clk);
      if (rst) begin
        check("rst_mid_write", 256'(wr), 256'(0));
        check("rst_mid_read", 256'(fread), 256'(0));
        model_reset();
        for (int c = 0; c < NCH; c++) fq[c].delete();
        did_reset = 1;
        post_rst  = 1;
      end else begin
        if (post_rst) begin
          check("post_rst_addr", 256'(waddr), 256'(0));
          post_rst = 0;
        end
        check("busy", 256'(busy), 256'(m_busy));
        check("write", 256'(wr), 256'(m_busy));
        check("frame_done", 256'(done), 256'(m_done));
        check("buf_sel", 256'(bsel), 256'(m_buf));
        exp_rd = '0;
        if (m_busy) begin
          if (!wreq) exp_rd[m_g] = 1'b1;
          check("address", 256'(waddr), 256'(m_addr));
          check("burstcount", 256'(bc), 256'(BL));
          check("data", wdata, (fq[m_g].size() > 0) ? fq[m_g][0] : '0);
        end
        check("fifo_read", 256'(fread), 256'(exp_rd));

        for (int c = 0; c < NCH; c++)
          if (fread[c] && fq[c].size() > 0) void'(fq[c].pop_front());

        m_done = '0;
        if (!m_busy) begin
          found = 0;
          for (int k = 0; k < NCH; k++) begin
            idx = (m_ptr + k) % NCH;
            if (!found && en[idx] && int'(flevel[idx*LW +: LW]) >= BL) begin
              found  = 1;
              m_busy = 1;
              m_g    = idx;
              m_beat = 0;
              m_addr = base_v[idx] + 27'(m_buf[idx] ? FW : 0) + 27'(m_wc[idx]);
            end
          end
        end else if (!wreq) begin
          m_beat++;
          if (m_beat == BL) begin
            bursts++;
            m_wc[m_g] += BL;
            if (m_wc[m_g] == FW) begin
              m_wc[m_g]   = 0;
              m_done[m_g] = 1'b1;
              m_buf[m_g]  = ~m_buf[m_g];
              frames++;
            end
            m_ptr  = (m_g + 1) % NCH;
            m_busy = 0;
          end
        end
      end
      @(posedge clk); #1;
    end

    check("bursts_seen", 256'(bursts >= 50), 256'(1));
    check("frames_seen", 256'(frames >= 10), 256'(1));
    check("reset_exercised", 256'(did_reset), 256'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
